// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception/ERET sequencer: cause codes, CP0 status
// bit positions and the sequencer state encoding.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_CAUSE_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_CAUSE_BREAK   = 5'd9;
  localparam logic [4:0] EXC_CAUSE_TEQ     = 5'd13;
  localparam logic [4:0] EXC_CAUSE_INT     = 5'd0;

  localparam int ST_IE  = 0;
  localparam int ST_SYS = 1;
  localparam int ST_BRK = 2;
  localparam int ST_TEQ = 3;
  localparam int ST_INT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAP  = 2'd1,
    S_ERET  = 2'd2,
    S_REDIR = 2'd3
  } state_t;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchroniser for the external interrupt line plus a rising-edge
// detector on the synchronised level.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer feeding CP0: evaluates traps, ERET and a latched
// external interrupt, and emits registered exception/eret/redirect pulses.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [4:0] CAUSE_SYSCALL = EXC_CAUSE_SYSCALL,
  parameter logic [4:0] CAUSE_BREAK   = EXC_CAUSE_BREAK,
  parameter logic [4:0] CAUSE_TEQ     = EXC_CAUSE_TEQ,
  parameter logic [4:0] CAUSE_INT     = EXC_CAUSE_INT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        teq_i,
  input  logic        teq_eq,
  input  logic        eret_i,
  input  logic        ext_int,
  input  logic [31:0] pc_i,
  input  logic [31:0] status,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] exc_pc,
  output logic        pc_redirect,
  output logic        stall,
  output logic        int_pending
);

  state_t state;
  logic   int_rise;
  logic   gie, take_sys, take_brk, take_teq, take_eret, take_int, take_trap;
  logic   unused;

  assign unused = ^status[31:5];

  int_sync #(.STAGES(SYNC_STAGES)) u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ext_int),
    .rise     (int_rise)
  );

  // ERET has no enable bit of its own and must work with interrupts off,
  // since handlers normally run with the global enable cleared.
  assign gie       = instr_valid & status[ST_IE];
  assign take_sys  = gie & syscall_i & status[ST_SYS];
  assign take_brk  = gie & break_i & status[ST_BRK];
  assign take_teq  = gie & teq_i & teq_eq & status[ST_TEQ];
  assign take_eret = instr_valid & eret_i;
  assign take_int  = gie & int_pending & status[ST_INT];
  assign take_trap = take_sys | take_brk | take_teq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      exception   <= 1'b0;
      eret        <= 1'b0;
      cause       <= '0;
      exc_pc      <= '0;
      pc_redirect <= 1'b0;
      stall       <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      exception   <= 1'b0;
      eret        <= 1'b0;
      pc_redirect <= 1'b0;
      stall       <= 1'b0;
      if (int_rise) int_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (take_trap) begin
            state     <= S_TRAP;
            exception <= 1'b1;
            stall     <= 1'b1;
            exc_pc    <= pc_i;
            cause     <= take_sys ? CAUSE_SYSCALL :
                         take_brk ? CAUSE_BREAK : CAUSE_TEQ;
          end else if (take_eret) begin
            state       <= S_ERET;
            eret        <= 1'b1;
            pc_redirect <= 1'b1;
            stall       <= 1'b1;
          end else if (take_int) begin
            state       <= S_TRAP;
            exception   <= 1'b1;
            stall       <= 1'b1;
            exc_pc      <= pc_i;
            cause       <= CAUSE_INT;
            int_pending <= 1'b0;
          end
        end
        S_TRAP: begin
          state       <= S_REDIR;
          pc_redirect <= 1'b1;
          stall       <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a cycle-level reference model predicts every
// post-edge output set; a monitor compares them on the falling edge.
module tb_exc_ctrl;

  localparam int SS = 2;

  typedef struct packed {
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    logic        pc_redirect;
    logic        stall;
    logic        int_pending;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, instr_valid, syscall_i, break_i, teq_i, teq_eq, eret_i, ext_int;
  logic [31:0] pc_i, status;
  logic        exception, eret, pc_redirect, stall, int_pending;
  logic [4:0]  cause;
  logic [31:0] exc_pc;

  int tests = 0;
  int failed = 0;

  exc_ctrl #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .syscall_i(syscall_i),
    .break_i(break_i), .teq_i(teq_i), .teq_eq(teq_eq), .eret_i(eret_i),
    .ext_int(ext_int), .pc_i(pc_i), .status(status), .exception(exception),
    .eret(eret), .cause(cause), .exc_pc(exc_pc), .pc_redirect(pc_redirect),
    .stall(stall), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  // Reference model: a non-empty schedule of future output flags means a
  // sequence is in flight, so no new request may be taken.
  obs_t       expq[$];
  logic [3:0] sched[$];   // {exception, eret, pc_redirect, stall}
  bit         hist[$];    // hist[k] = ext_int sampled k+1 edges ago
  bit         pend;
  logic [4:0] m_cause;
  logic [31:0] m_pc;

  task automatic model_edge();
    obs_t o;
    logic [3:0] fl;
    bit rise, newpend, g, ts, tb, tt;
    if (rst) begin
      sched.delete();
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back(1'b0);
      pend = 1'b0; m_cause = '0; m_pc = '0;
      o = '0;
    end else begin
      rise = hist[SS-1] && !hist[SS];
      newpend = pend | rise;
      fl = 4'b0000;
      if (sched.size() > 0) begin
        fl = sched.pop_front();
      end else if (instr_valid) begin
        g  = status[0];
        ts = g & syscall_i & status[1];
        tb = g & break_i & status[2];
        tt = g & teq_i & teq_eq & status[3];
        if (ts || tb || tt) begin
          m_cause = ts ? 5'd8 : (tb ? 5'd9 : 5'd13);
          m_pc = pc_i;
          fl = 4'b1001;
          sched.push_back(4'b0011); sched.push_back(4'b0000);
        end else if (eret_i) begin
          fl = 4'b0111;
          sched.push_back(4'b0000);
        end else if (g && pend && status[4]) begin
          m_cause = 5'd0;
          m_pc = pc_i;
          newpend = 1'b0;
          fl = 4'b1001;
          sched.push_back(4'b0011); sched.push_back(4'b0000);
        end
      end
      pend = newpend;
      hist.push_front(ext_int);
      void'(hist.pop_back());
      o.exception   = fl[3];
      o.eret        = fl[2];
      o.pc_redirect = fl[1];
      o.stall       = fl[0];
      o.cause       = m_cause;
      o.exc_pc      = m_pc;
      o.int_pending = pend;
    end
    expq.push_back(o);
  endtask

  task automatic step(input bit r, iv, sy, bk, tq, eq, er, ex,
                      input logic [31:0] pc, st);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; instr_valid = iv; syscall_i = sy; break_i = bk; teq_i = tq;
    teq_eq = eq; eret_i = er; ext_int = ex; pc_i = pc; status = st;
  endtask

  task automatic idle(input int n, input bit ex);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ex, 32'h0, 32'h1F);
  endtask

  obs_t mon_e, mon_a;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      mon_a = '{exception, eret, cause, exc_pc, pc_redirect, stall, int_pending};
      tests++;
      if (mon_a !== mon_e) begin
        failed++;
        $display("FAIL outputs t=%0t: got exc=%b eret=%b cause=%0d pc=%h redir=%b stall=%b ip=%b, expected exc=%b eret=%b cause=%0d pc=%h redir=%b stall=%b ip=%b",
                 $time, mon_a.exception, mon_a.eret, mon_a.cause, mon_a.exc_pc,
                 mon_a.pc_redirect, mon_a.stall, mon_a.int_pending,
                 mon_e.exception, mon_e.eret, mon_e.cause, mon_e.exc_pc,
                 mon_e.pc_redirect, mon_e.stall, mon_e.int_pending);
      end
      tests++;
      if (exception && eret) begin
        failed++;
        $display("FAIL exc_eret_excl: got exception=1 eret=1, expected not both");
      end
    end
  end

  bit r, ex;
  initial begin
    rst = 1; instr_valid = 0; syscall_i = 0; break_i = 0; teq_i = 0; teq_eq = 0;
    eret_i = 0; ext_int = 1; pc_i = 0; status = 0;
    // reset held with the interrupt line already high
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(6, 1);
    // BREAK beats the pending interrupt, INT follows on next valid cycle
    step(0, 1, 0, 1, 0, 0, 0, 1, 32'h00400100, 32'h1F);
    idle(3, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1, 32'h00400104, 32'h1F);
    idle(4, 1);
    // SYSCALL
    step(0, 1, 1, 0, 0, 0, 0, 1, 32'h00400020, 32'h1F);
    idle(4, 1);
    // TEQ: not equal, masked, taken
    step(0, 1, 0, 0, 1, 0, 0, 1, 32'h00400030, 32'h1F);
    idle(2, 1);
    step(0, 1, 0, 0, 1, 1, 0, 1, 32'h00400034, 32'h17);
    idle(2, 1);
    step(0, 1, 0, 0, 1, 1, 0, 1, 32'h00400038, 32'h1F);
    idle(4, 1);
    // ERET
    step(0, 1, 0, 0, 0, 0, 1, 1, 32'h00400040, 32'h1F);
    idle(3, 1);
    // reset during the TRAP cycle
    step(0, 1, 1, 0, 0, 0, 0, 1, 32'h00400050, 32'h1F);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1F);
    idle(3, 0);
    // randomized traffic
    ex = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) ex = ~ex;
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 5) == 0), ex, $urandom,
           ($urandom_range(0, 1) != 0) ? 32'h1F : $urandom);
    end
    idle(2, ex);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (expq.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
